is_odd: RTL and testbench

- Registered odd-number detector for the number-analyzer datapath.
- Samples a WIDTH-bit unsigned word when in_valid is high and flags it odd when bit 0 is 1.
- Keeps saturating running tallies of odd and even words, read by the analyzer FSM and by status logic.
- Pure classification: no arithmetic on the operand beyond reading the LSB.

---
 rtl/num_analyzer_pkg.sv | 13 +
 rtl/sat_counter.sv | 26 ++
 rtl/is_odd.sv | 61 ++++++
 tb/tb_is_odd.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/num_analyzer_pkg.sv
// Shared defaults for the number-analyzer detectors.
// Sibling classifiers import this package, so keep the defaults here.
package num_analyzer_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 16;

  // Odd/even classification only ever needs the least significant bit.
  function automatic logic lsb_is_odd(input logic lsb);
    return lsb;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Once it reaches all-ones it stays there; it never wraps and has no overflow flag.
module sat_counter
  import num_analyzer_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // A clear overrides a same-cycle increment, so the counter reads 0 rather than 1.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/is_odd.sv
// Registered odd-number detector that keeps saturating tallies of odd and even words.
// Every output comes straight from a flop; only a[0] can affect the results.
module is_odd
  import num_analyzer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  output logic             o,
  output logic             out_valid,
  output logic [CNT_W-1:0] odd_count,
  output logic [CNT_W-1:0] even_count
);

  logic word_odd;
  logic odd_inc;
  logic even_inc;
  logic unused_a;

  assign word_odd = lsb_is_odd(a[0]);
  assign odd_inc  = in_valid && word_odd;
  assign even_inc = in_valid && !word_odd;

  // The upper bits are deliberately ignored; this reduction only marks them as consumed.
  assign unused_a = ^a;

  // o holds its last value across idle cycles, while out_valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      o         <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        o <= word_odd;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_odd_count (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (odd_inc),
    .count (odd_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_even_count (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (even_inc),
    .count (even_count)
  );

endmodule

// File: tb/tb_is_odd.sv
// Scoreboard bench for is_odd: a default-width instance and a 2-bit-counter instance share one stimulus.
// Expected values come from a behavioural model, are queued when inputs are driven, and are popped one cycle later.
module tb_is_odd;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid;
  logic [31:0] a;

  logic        o, out_valid;
  logic [15:0] odd_count, even_count;
  logic        s_o, s_out_valid;
  logic [1:0]  s_odd_count, s_even_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        o;
    logic        ov;
    logic [15:0] odd;
    logic [15:0] even;
    logic [1:0]  s_odd;
    logic [1:0]  s_even;
  } exp_t;

  exp_t scoreboard[$];

  // Model state
  logic        m_o = 1'b0;
  logic [15:0] m_odd = '0, m_even = '0;
  logic [1:0]  m_s_odd = '0, m_s_even = '0;

  is_odd dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .a(a),
    .o(o), .out_valid(out_valid), .odd_count(odd_count), .even_count(even_count)
  );

  is_odd #(.WIDTH(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .a(a),
    .o(s_o), .out_valid(s_out_valid), .odd_count(s_odd_count), .even_count(s_even_count)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model and queue what must appear after the edge.
  task automatic applyStimulus(input logic r, input logic c, input logic v, input logic [31:0] av);
    exp_t e;
    rst = r; clr = c; in_valid = v; a = av;
    if (r) begin
      m_o = 1'b0; m_odd = '0; m_even = '0; m_s_odd = '0; m_s_even = '0;
      e.ov = 1'b0;
    end else begin
      e.ov = v;
      if (v) m_o = av[0];
      if (c) begin
        m_odd = '0; m_even = '0; m_s_odd = '0; m_s_even = '0;
      end else if (v && av[0]) begin
        if (m_odd != 16'hFFFF) m_odd = m_odd + 16'd1;
        if (m_s_odd != 2'b11) m_s_odd = m_s_odd + 2'd1;
      end else if (v) begin
        if (m_even != 16'hFFFF) m_even = m_even + 16'd1;
        if (m_s_even != 2'b11) m_s_even = m_s_even + 2'd1;
      end
    end
    e.o = m_o; e.odd = m_odd; e.even = m_even; e.s_odd = m_s_odd; e.s_even = m_s_even;
    scoreboard.push_back(e);
  endtask

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for the edge, sample 1 time unit later, and compare against the oldest queued entry.
  task automatic checkOutput(input string step);
    exp_t e;
    @(posedge clk);
    #1;
    checks++;
    assert (scoreboard.size() != 0) else begin
      errors++;
      $error("[TB] FAIL %s scoreboard: observed empty expected entry", step);
    end
    if (scoreboard.size() != 0) begin
      e = scoreboard.pop_front();
      compare({step, " o"},          {31'b0, o},            {31'b0, e.o});
      compare({step, " out_valid"},  {31'b0, out_valid},    {31'b0, e.ov});
      compare({step, " odd_count"},  {16'b0, odd_count},    {16'b0, e.odd});
      compare({step, " even_count"}, {16'b0, even_count},   {16'b0, e.even});
      compare({step, " sat o"},      {31'b0, s_o},          {31'b0, e.o});
      compare({step, " sat odd"},    {30'b0, s_odd_count},  {30'b0, e.s_odd});
      compare({step, " sat even"},   {30'b0, s_even_count}, {30'b0, e.s_even});
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; a = '0;
    #2;

    // Reset held with a valid odd word present
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFFFFFF); checkOutput("reset0");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFFFFFF); checkOutput("reset1");

    // Back-to-back stream
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF); checkOutput("stream_ffffffff");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFFFFFE); checkOutput("stream_fffffffe");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h00000000); checkOutput("stream_zero");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h80000001); checkOutput("stream_80000001");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hD261864B); checkOutput("stream_d261864b");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFE0000); checkOutput("stream_fffe0000");

    // Gaps: o must hold through the idle cycle
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h00000003); checkOutput("gap_3");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h00000000); checkOutput("gap_idle");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h00000004); checkOutput("gap_4");

    // Unknown upper bits must not disturb anything
    applyStimulus(1'b0, 1'b0, 1'b1, {31'bx, 1'b1}); checkOutput("x_upper");

    // Clear colliding with an accepted word
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h00000001); checkOutput("clr_collision");

    // Saturation of the 2-bit counters
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h00000001 + (32'(i) << 4));
      checkOutput($sformatf("sat_%0d", i));
    end

    // Reset in the middle of an odd stream, then counting restarts
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h00000007); checkOutput("mid_pre");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h00000009); checkOutput("mid_rst");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000000B); checkOutput("mid_post");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h00000000); checkOutput("mid_idle");

    checks++;
    assert (scoreboard.size() == 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_drain: observed %0d expected 0", scoreboard.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
